ifu_fetch: RTL and testbench

Instruction fetch stage sitting directly upstream of the PC/branch unit and the ID stage. It fetches the instruction at the current pc from instruction memory over a simple request/response handshake, then presents it to ID as a registered IDreg bundle (valid, pc, inst). It holds that bundle while ID stalls (Data_Conflict/suspend). It discards in-flight fetches on flush and synthesizes a fault on bus error or timeout. One fetch is outstanding at most; pc advances only when ID consumes, so no speculative refetch is needed on jump.

---
 rtl/ifu_fetch.sv | 123 ++++++++++++
 tb/tb_ifu_fetch.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one outstanding imem fetch, result held in the IDreg bundle
// until ID consumes it, with flush discard and bus-error/timeout fault synthesis.
module ifu_fetch #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        id_stall,
    input  logic        flush,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,
    output logic        IDreg_valid,
    output logic [31:0] IDreg_pc,
    output logic [31:0] IDreg_inst,
    output logic        IDreg_fault
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_VALID = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              drop;
    logic [31:0]       pend_pc;

    logic              in_wait;
    logic              resp_hit;
    logic              tmo;
    logic              kill;
    logic              wait_done;
    logic              deliver;
    logic              bad_fetch;
    logic              release_id;

    // Fetch completion events, shared by the FSM and the datapath registers
    assign in_wait    = (state == S_WAIT);
    assign resp_hit   = in_wait && imem_resp_valid;
    assign tmo        = in_wait && !imem_resp_valid && (cnt == CNT_W'(TIMEOUT - 1));
    assign kill       = drop || flush;
    assign wait_done  = resp_hit || tmo;
    assign deliver    = wait_done && !kill;
    assign bad_fetch  = tmo || (imem_resp_valid && imem_resp_err);
    assign release_id = (state == S_VALID) && (flush || !id_stall);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_REQ;
            S_REQ:   if (imem_req_ready) state_nxt = S_WAIT;
            S_WAIT:  if (wait_done) state_nxt = kill ? S_REQ : S_VALID;
            S_VALID: if (release_id) state_nxt = S_REQ;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request is gated by reset so it drops as soon as reset is asserted
    always_comb begin
        imem_req_valid = 1'b0;
        imem_req_addr  = pc;
        if (state == S_REQ && reset) begin
            imem_req_valid = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt         <= '0;
            drop        <= 1'b0;
            pend_pc     <= '0;
            IDreg_valid <= 1'b0;
            IDreg_pc    <= '0;
            IDreg_inst  <= '0;
            IDreg_fault <= 1'b0;
        end else begin
            if (state == S_REQ && imem_req_ready) begin
                pend_pc <= pc;
                cnt     <= '0;
            end

            if (in_wait) begin
                if (wait_done) begin
                    cnt  <= '0;
                    drop <= 1'b0;
                end else begin
                    cnt  <= cnt + CNT_W'(1);
                    drop <= kill;
                end
            end

            if (deliver) begin
                IDreg_valid <= 1'b1;
                IDreg_pc    <= pend_pc;
                IDreg_inst  <= bad_fetch ? NOP_INST : imem_resp_data;
                IDreg_fault <= bad_fetch;
            end else if (release_id) begin
                IDreg_valid <= 1'b0;
                IDreg_fault <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: handshake timing, stall hold, flush drop, bus error,
// timeout fault and reset in VALID, all against hand-computed expectations.
module tb_ifu_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        id_stall;
    logic        flush;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        IDreg_valid;
    logic [31:0] IDreg_pc;
    logic [31:0] IDreg_inst;
    logic        IDreg_fault;

    int n_tests = 0;
    int n_fail  = 0;

    ifu_fetch #(.TIMEOUT(255), .NOP_INST(32'h0000_0013)) dut (
        .clock           (clock),
        .reset           (reset),
        .pc              (pc),
        .id_stall        (id_stall),
        .flush           (flush),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .IDreg_valid     (IDreg_valid),
        .IDreg_pc        (IDreg_pc),
        .IDreg_inst      (IDreg_inst),
        .IDreg_fault     (IDreg_fault)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_bundle(input string tag, input logic v, input logic [31:0] p,
                              input logic [31:0] i, input logic f);
        chk({tag, "_valid"}, 32'(IDreg_valid), 32'(v));
        chk({tag, "_pc"},    IDreg_pc, p);
        chk({tag, "_inst"},  IDreg_inst, i);
        chk({tag, "_fault"}, 32'(IDreg_fault), 32'(f));
    endtask

    initial begin
        int n;
        reset           = 1'b0;
        pc              = 32'h8000_0000;
        id_stall        = 1'b0;
        flush           = 1'b0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        imem_resp_err   = 1'b0;

        tick();
        tick();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk_bundle("rst", 1'b0, 32'h0, 32'h0, 1'b0);

        // Basic fetch: IDLE (cycle 1), REQ (cycle 2), WAIT (cycle 3), VALID (cycle 4)
        reset = 1'b1;
        #1;
        chk("idle_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        chk("c2_req_valid", 32'(imem_req_valid), 32'd1);
        chk("c2_req_addr", imem_req_addr, 32'h8000_0000);
        tick();
        chk("c3_req_valid", 32'(imem_req_valid), 32'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0010_0093;
        id_stall        = 1'b1;
        tick();
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'hffff_ffff;
        chk_bundle("c4", 1'b1, 32'h8000_0000, 32'h0010_0093, 1'b0);

        // Held through a 5-cycle stall with no new request
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_bundle("stall", 1'b1, 32'h8000_0000, 32'h0010_0093, 1'b0);
            chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        end
        id_stall = 1'b0;
        tick();
        pc = 32'h8000_0004;
        #1;
        chk("consume_valid", 32'(IDreg_valid), 32'd0);
        chk("consume_req_valid", 32'(imem_req_valid), 32'd1);
        chk("consume_req_addr", imem_req_addr, 32'h8000_0004);

        // Flush in WAIT, late response dropped
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hdead_beef;
        tick();
        imem_resp_valid = 1'b0;
        chk("drop_valid", 32'(IDreg_valid), 32'd0);
        chk("drop_req_valid", 32'(imem_req_valid), 32'd1);
        chk("drop_req_addr", imem_req_addr, 32'h8000_0004);

        // Flush coincident with response
        tick();
        flush           = 1'b1;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h1111_1111;
        tick();
        flush           = 1'b0;
        imem_resp_valid = 1'b0;
        chk("coinc_valid", 32'(IDreg_valid), 32'd0);
        chk("coinc_req_valid", 32'(imem_req_valid), 32'd1);

        // Drop flag must be clear again: next response is delivered
        tick();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0020_0113;
        tick();
        imem_resp_valid = 1'b0;
        chk_bundle("after_drop", 1'b1, 32'h8000_0004, 32'h0020_0113, 1'b0);

        // Bus error gives a fault bundle
        tick();
        pc = 32'h8000_0008;
        tick();
        imem_resp_valid = 1'b1;
        imem_resp_err   = 1'b1;
        imem_resp_data  = 32'h1234_5678;
        tick();
        imem_resp_valid = 1'b0;
        imem_resp_err   = 1'b0;
        chk_bundle("err", 1'b1, 32'h8000_0008, 32'h0000_0013, 1'b1);

        // Flush in VALID wins over stall; fault clears with valid
        id_stall = 1'b1;
        flush    = 1'b1;
        tick();
        chk("vflush_valid", 32'(IDreg_valid), 32'd0);
        chk("vflush_fault", 32'(IDreg_fault), 32'd0);
        chk("vflush_req_valid", 32'(imem_req_valid), 32'd1);

        // Flush in REQ has no effect on the fetch that follows
        tick();
        flush = 1'b0;
        chk("reqflush_req_valid", 32'(imem_req_valid), 32'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0030_0193;
        tick();
        imem_resp_valid = 1'b0;
        chk_bundle("reqflush", 1'b1, 32'h8000_0008, 32'h0030_0193, 1'b0);

        // REQ holds while memory is not ready
        id_stall = 1'b0;
        tick();
        pc             = 32'h8000_000c;
        imem_req_ready = 1'b0;
        tick();
        chk("notready_req_valid", 32'(imem_req_valid), 32'd1);
        chk("notready_req_addr", imem_req_addr, 32'h8000_000c);
        imem_req_ready = 1'b1;
        id_stall       = 1'b1;
        tick();

        // Timeout: fault presented after 255 WAIT cycles with no response
        n = 0;
        while (IDreg_valid !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk("tmo_cycles", 32'(n), 32'd255);
        chk_bundle("tmo", 1'b1, 32'h8000_000c, 32'h0000_0013, 1'b1);

        // Reset while VALID clears everything on that edge
        reset = 1'b0;
        tick();
        chk("rst2_req_valid", 32'(imem_req_valid), 32'd0);
        chk_bundle("rst2", 1'b0, 32'h0, 32'h0, 1'b0);
        reset = 1'b1;
        tick();
        chk("rst2_rel_req_valid", 32'(imem_req_valid), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
